// File: rtl/xnor_diff_rx.sv
// Receive end of the XNOR differential line link: decodes line bits, hunts for
// the sync word, deserializes one data word plus odd parity, and holds it for a valid/ready consumer.
module xnor_diff_rx #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_line,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              par_err,
  output logic              overrun,
  output logic              sync_lock
);

  localparam int HCNT_W = $clog2(SYNC_W + 1);
  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [HCNT_W-1:0] HUNT_FULL = HCNT_W'(SYNC_W);
  localparam logic [HCNT_W-1:0] HUNT_LAST = HCNT_W'(SYNC_W - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_DATA,
    ST_PARITY
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prev_line;
  logic [SYNC_W-1:0]   r_sync_sh;
  logic [HCNT_W-1:0]   r_hunt_cnt;
  logic [BCNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_valid;
  logic                r_par_err;
  logic                r_overrun;

  logic                w_d;
  logic [SYNC_W-1:0]   w_sync_next;
  logic                w_match;
  logic                w_data_last;
  logic                w_par_bit;
  logic                w_par_err;
  logic                w_load;
  logic                w_drop;

  // The line carries ~(d ^ previous line), so equal consecutive line levels mean d = 1.
  assign w_d         = ~(rx_line ^ r_prev_line);
  assign w_sync_next = {r_sync_sh[SYNC_W-2:0], w_d};
  assign w_match     = bit_en && (r_state == ST_HUNT) && (w_sync_next == SYNC_WORD)
                       && (r_hunt_cnt >= HUNT_LAST);
  assign w_data_last = (r_bit_cnt == BIT_LAST);
  assign w_par_bit   = bit_en && (r_state == ST_PARITY);
  assign w_par_err   = (w_d != ~^r_data);
  assign w_load      = w_par_bit && (!r_m_valid || m_ready);
  assign w_drop      = w_par_bit && r_m_valid && !m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first guarantees every path writes the
  // signal, so no latch is inferred for w_state_nxt.
  always_comb begin
    w_state_nxt = r_state;
    if (bit_en) begin
      unique case (r_state)
        ST_HUNT:   if (w_match) w_state_nxt = ST_DATA;
        ST_DATA:   if (w_data_last) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_HUNT;
        default:   w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // NOTE: every register here, including the shift registers, is reset so
  // that a mid-frame reset restarts decoding from a known idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_line <= 1'b1;
      r_sync_sh   <= '0;
      r_hunt_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_data      <= '0;
    end else if (bit_en) begin
      r_prev_line <= rx_line;
      unique case (r_state)
        ST_HUNT: begin
          r_sync_sh <= w_sync_next;
          if (r_hunt_cnt != HUNT_FULL) r_hunt_cnt <= r_hunt_cnt + 1'b1;
          if (w_match) r_bit_cnt <= '0;
        end
        ST_DATA: begin
          r_data    <= {r_data[DATA_W-2:0], w_d};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        ST_PARITY: begin
          r_sync_sh  <= '0;
          r_hunt_cnt <= '0;
        end
        default: begin
          r_sync_sh  <= '0;
          r_hunt_cnt <= '0;
        end
      endcase
    end
  end

  // One-entry output buffer; a load may coincide with the consumer draining the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_par_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_load) begin
        r_m_data  <= r_data;
        r_par_err <= w_par_err;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign par_err   = r_par_err;
  assign overrun   = r_overrun;
  assign sync_lock = (r_state != ST_HUNT);

endmodule

// File: tb/tb_xnor_diff_rx.sv
// Bench for xnor_diff_rx: queue-based frame model compared every cycle, plus
// directed frames with literal expectations.
module tb_xnor_diff_rx;

  localparam int DATA_W = 8;
  localparam int SYNC_W = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       bit_en  = 1'b0;
  logic       rx_line = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       par_err;
  logic       overrun;
  logic       sync_lock;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xnor_diff_rx #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_WORD(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .rx_line   (rx_line),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .par_err   (par_err),
    .overrun   (overrun),
    .sync_lock (sync_lock)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: decoded bits collected in queues; a frame is the DATA_W+1 bits after the sync.
  logic       mdl_prev   = 1'b1;
  bit         mdl_locked = 1'b0;
  bit         hunt_q[$];
  bit         frame_q[$];
  logic [7:0] exp_data   = 8'h00;
  logic       exp_valid  = 1'b0;
  logic       exp_perr   = 1'b0;
  logic       exp_ovr    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_prev   = 1'b1;
      mdl_locked = 1'b0;
      hunt_q.delete();
      frame_q.delete();
      exp_data   = 8'h00;
      exp_valid  = 1'b0;
      exp_perr   = 1'b0;
      exp_ovr    = 1'b0;
    end else begin
      bit         done;
      bit         perr;
      bit         d;
      logic [7:0] word;
      logic [7:0] w;
      done = 1'b0;
      perr = 1'b0;
      word = 8'h00;
      if (bit_en) begin
        d = ~(rx_line ^ mdl_prev);
        mdl_prev = rx_line;
        if (!mdl_locked) begin
          hunt_q.push_back(d);
          if (hunt_q.size() > SYNC_W) void'(hunt_q.pop_front());
          if (hunt_q.size() == SYNC_W) begin
            w = 8'h00;
            foreach (hunt_q[i]) w = {w[6:0], hunt_q[i]};
            if (w == SYNC) begin
              mdl_locked = 1'b1;
              frame_q.delete();
            end
          end
        end else begin
          frame_q.push_back(d);
          if (frame_q.size() == DATA_W + 1) begin
            for (int i = 0; i < DATA_W; i++) word = {word[6:0], frame_q[i]};
            perr = ((^word) ^ frame_q[DATA_W]) == 1'b0;
            done = 1'b1;
            mdl_locked = 1'b0;
            hunt_q.delete();
          end
        end
      end
      exp_ovr = 1'b0;
      if (done && exp_valid && !m_ready) begin
        exp_ovr = 1'b1;
      end else if (done) begin
        exp_data  = word;
        exp_perr  = perr;
        exp_valid = 1'b1;
      end else if (exp_valid && m_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  logic [7:0] dut_acc[$];

  always @(negedge clk) begin
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("m_data", 32'(m_data), 32'(exp_data));
      check("par_err", 32'(par_err), 32'(exp_perr));
    end
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("sync_lock", 32'(sync_lock), 32'(mdl_locked));
    if (m_valid && m_ready) dut_acc.push_back(m_data);
  end

  // Stimulus: inputs change 2 time units after the rising edge.
  logic enc_line = 1'b1;
  int   gap      = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic d);
    enc_line = ~(d ^ enc_line);
    for (int i = 0; i < gap; i++) begin
      tick();
      bit_en  = 1'b0;
      rx_line = ~rx_line;
    end
    tick();
    bit_en  = 1'b1;
    rx_line = enc_line;
  endtask

  task automatic idle();
    tick();
    bit_en = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit good_par, input bit ready_at_par);
    logic p;
    p = good_par ? ~^data : ^data;
    send_bits(SYNC, 8);
    send_bits(data, 8);
    send_bit(p);
    if (ready_at_par) m_ready = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    #1;
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    check("reset par_err", 32'(par_err), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset sync_lock", 32'(sync_lock), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Clean frame
    m_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0);
    idle();
    #1;
    check("clean valid", 32'(m_valid), 32'd1);
    check("clean data", 32'(m_data), 32'h3C);
    check("clean par_err", 32'(par_err), 32'd0);
    tick();
    #1;
    check("clean valid drop", 32'(m_valid), 32'd0);

    // Bad parity still delivered
    send_frame(8'h3C, 1'b0, 1'b0);
    idle();
    #1;
    check("badpar valid", 32'(m_valid), 32'd1);
    check("badpar data", 32'(m_data), 32'h3C);
    check("badpar par_err", 32'(par_err), 32'd1);
    tick();
    tick();

    // Overrun
    m_ready = 1'b0;
    dut_acc.delete();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle();
    #1;
    check("ovr pulse", 32'(overrun), 32'd1);
    check("ovr held data", 32'(m_data), 32'h3C);
    check("ovr held valid", 32'(m_valid), 32'd1);
    tick();
    #1;
    check("ovr pulse end", 32'(overrun), 32'd0);
    check("ovr still held", 32'(m_data), 32'h3C);
    m_ready = 1'b1;
    tick();
    tick();
    #1;
    check("ovr drained count", 32'(dut_acc.size()), 32'd1);
    if (dut_acc.size() > 0) check("ovr drained word", 32'(dut_acc[0]), 32'h3C);
    check("ovr valid after drain", 32'(m_valid), 32'd0);

    // Simultaneous drain and load
    m_ready = 1'b0;
    dut_acc.delete();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1);
    idle();
    #1;
    check("swap overrun", 32'(overrun), 32'd0);
    check("swap data", 32'(m_data), 32'h81);
    check("swap valid", 32'(m_valid), 32'd1);
    tick();
    tick();
    check("swap count", 32'(dut_acc.size()), 32'd2);
    if (dut_acc.size() == 2) begin
      check("swap first", 32'(dut_acc[0]), 32'h3C);
      check("swap second", 32'(dut_acc[1]), 32'h81);
    end

    // Reset mid-DATA with a word held
    m_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_bits(SYNC, 8);
    send_bits(8'h05, 4);
    tick();
    bit_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_data", 32'(m_data), 32'd0);
    check("rst par_err", 32'(par_err), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst sync_lock", 32'(sync_lock), 32'd0);
    tick();
    rst_n    = 1'b1;
    enc_line = 1'b1;
    rx_line  = 1'b1;
    m_ready  = 1'b1;
    tick();
    send_frame(8'h55, 1'b1, 1'b0);
    idle();
    #1;
    check("post-rst data", 32'(m_data), 32'h55);
    check("post-rst par_err", 32'(par_err), 32'd0);
    check("post-rst valid", 32'(m_valid), 32'd1);

    // Sparse strobes, sync pattern inside the data
    gap = 3;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle();
    #1;
    check("sparse data", 32'(m_data), 32'hA5);
    check("sparse par_err", 32'(par_err), 32'd0);
    check("sparse valid", 32'(m_valid), 32'd1);
    send_frame(8'hD2, 1'b1, 1'b0);
    idle();
    #1;
    check("sparse2 data", 32'(m_data), 32'hD2);
    check("sparse2 valid", 32'(m_valid), 32'd1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xnor_diff_rx.md
# xnor_diff_rx

Serial receive end of the XNOR differential line link. It recovers data bits from a line driven by an XNOR differential encoder, where each line bit is `tx[n] = ~(d[n] ^ tx[n-1])`. It hunts for a sync word, deserializes one data word plus an odd-parity bit, and presents the word on a valid/ready output port. It sits between the line sampler, which supplies `rx_line` and the `bit_en` strobe, and the word-level consumer.

## Interface

- `DATA_W`, 8, data word width in bits.
- `SYNC_W`, 8, sync word width in bits.
- `SYNC_WORD`, 8'hA5, sync pattern in decoded bits, sent MSB first.

- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `bit_en`  in  1  bit strobe; `rx_line` is sampled only when this is high.
- `rx_line`  in  1  encoded serial line.
- `m_data`  out  DATA_W  received word.
- `m_valid`  out  1  `m_data` and `par_err` are valid.
- `m_ready`  in  1  consumer accepts the word.
- `par_err`  out  1  parity error flag for the held word; a sideband of `m_data`.
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped.
- `sync_lock`  out  1  high while in DATA or PARITY.

## Operation

- **Decode:** on every `bit_en`:
  - decoded bit `d = ~(rx_line ^ prev_line)`;
  - then `prev_line <= rx_line`.
  - `prev_line` resets to 1, which is the encoder's idle line state.
- **Idle cycles:** when `bit_en` is low, no state, counter or shift register changes, whatever `rx_line` does.
- **Bit order:** data bits are MSB first.
- **FSM states:** HUNT, DATA, PARITY.
- **HUNT:**
  - Shift `d` into the `SYNC_W` shift register; a hunt counter saturates at `SYNC_W`.
  - Match fires when `{shreg[SYNC_W-2:0], d} == SYNC_WORD` and at least `SYNC_W` bits (including the current one) have arrived since entering HUNT.
  - On match, go to DATA with the bit counter at 0.
- **DATA:**
  - Shift `d` into the data register and increment the bit counter.
  - After the `DATA_W`-th bit, go to PARITY.
- **PARITY:**
  - Expected parity is `~^data` (odd parity overall).
  - `par_err = (d != ~^data)`.
  - Always return to HUNT, with the hunt counter and shift register cleared.
- **Output buffer (one entry):**
  - At the PARITY bit, the frame loads if the buffer is empty, or if `m_valid && m_ready` in that same cycle. Loading sets `m_data` and `par_err`, and `m_valid` is 1.
  - Otherwise the frame is dropped, the held word is unchanged, and `overrun` pulses for one cycle.
  - A word with a parity error is still delivered; it is never dropped for that reason.
- **Handshake:**
  - Transfer happens on `m_valid && m_ready`.
  - `m_data` and `par_err` stay stable while `m_valid && !m_ready`.
  - After a transfer with no simultaneous load, `m_valid` goes to 0.
  - `m_ready` is ignored while `m_valid` is 0.
- **Reset values:**
  - `m_data` = 0, `m_valid` = 0, `par_err` = 0, `overrun` = 0, `sync_lock` = 0.
  - State is HUNT, all counters and shift registers are 0, and `prev_line` = 1.

## Timing

- `m_valid` rises in the cycle after the clock edge at which `bit_en` sampled the parity bit. Latency is 1 clock from the last line bit.
- `sync_lock` rises the cycle after the matching sync bit. It falls the cycle after the parity bit.
- `overrun` is registered. It is high for exactly the one cycle following the parity-bit edge.
- Minimum frame length is `SYNC_W + DATA_W + 1` strobes. Back-to-back frames need no idle strobes.
- `bit_en` may be high on consecutive cycles, or sparse with arbitrary gaps.
- Asserting `rst_n` low mid-frame does the following immediately:
  - all outputs take their reset values;
  - a held, unconsumed word is lost;
  - decoding restarts in HUNT with `prev_line` = 1.
- Removal of reset is treated as synchronous to `clk`; the block needs no extra cycles after it.

## Test plan

- **Clean frame.** Stimulus: encoder starts from line 1; send sync 0xA5, then data 0x3C, then parity 1, with `m_ready` = 1. Response: one cycle after the parity strobe, `m_valid` = 1, `m_data` = 0x3C and `par_err` = 0. `m_valid` drops the next cycle.
- **Bad parity.** Stimulus: same frame with parity sent as 0. Response: `m_data` = 0x3C and `par_err` = 1; the word is still delivered.
- **Overrun.** Stimulus: `m_ready` = 0; send frame 0x3C, then frame 0x81. Response:
  - `overrun` is high for exactly 1 cycle after the second parity strobe;
  - `m_data` stays 0x3C with `m_valid` = 1;
  - raising `m_ready` then yields only 0x3C.
- **Simultaneous drain and load.** Stimulus: word 0x3C is held, and `m_ready` = 1 in the same cycle that the parity strobe of frame 0x81 arrives. Response: `overrun` = 0, `m_data` = 0x81 and `m_valid` = 1 on the next cycle.
- **Reset mid-DATA.** Stimulus: pull `rst_n` low after 4 data bits. Response: all outputs are 0 in the same cycle. A full frame 0x55 sent after reset decodes to `m_data` = 0x55 with `par_err` = 0.
- **Sparse strobes and false sync.** Stimulus:
  - `bit_en` on every 4th cycle, with `rx_line` toggled on the non-strobe cycles;
  - the data bits contain the pattern 0xA5.

  Response: the decoded word is correct, and the pattern inside the data does not restart the frame.
